// File: rtl/key_debouncer_pkg.sv
// Shared definitions for the key debouncer: FSM state encoding and the
// default qualification window for a 50 MHz system clock.
package key_debouncer_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED    = 2'd0,
        ST_PRESS_CHK   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_RELEASE_CHK = 2'd3
    } state_e;

    // 10 ms at 50 MHz.
    localparam int unsigned DEBOUNCE_CYCLES_50MHZ = 500000;

endpackage

// File: rtl/key_debouncer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input; both flops
// clear to 0 on synchronous reset so a released switch is assumed.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state is always written with non-blocking assignments
    // so every flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_debouncer.sv
// Push-button debouncer: synchronizes the raw key, qualifies each level change
// over DEBOUNCE_CYCLES samples and emits a clean level plus press/release strobes.
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
    parameter int unsigned CNT_W           = 20,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic key_norm;
    logic key_sync;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               key_level_q, key_level_d;
    logic               press_q, press_d;
    logic               release_q, release_d;
    logic               busy_q, busy_d;

    assign key_norm = KEY_ACTIVE_LOW ? ~key_raw : key_raw;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (key_norm),
        .q_o   (key_sync)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RELEASED: begin
                if (key_sync) begin
                    state_d = ST_PRESS_CHK;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_PRESS_CHK: begin
                if (!key_sync) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!key_sync) begin
                    state_d = ST_RELEASE_CHK;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_RELEASE_CHK: begin
                if (key_sync) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the registered state and registered again; the
    // level holds through RELEASE_CHK and strobes mark its edges.
    always_comb begin
        key_level_d = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_CHK);
        busy_d      = (state_q == ST_PRESS_CHK) || (state_q == ST_RELEASE_CHK);
        press_d     = key_level_d & ~key_level_q;
        release_d   = ~key_level_d & key_level_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RELEASED;
            cnt_q       <= '0;
            key_level_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_level_q <= key_level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            busy_q      <= busy_d;
        end
    end

    assign key_level     = key_level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer: expected strobes are queued with the
// cycle they must appear in and matched by a monitor on the falling edge.
module tb_key_debouncer;
    import key_debouncer_pkg::*;

    localparam int unsigned D   = 8;
    // Drive at a falling edge -> first sampling edge one later -> output D+2 after that.
    localparam int unsigned LAT = D + 3;

    logic clk = 1'b0;
    logic reset;
    logic key_raw;
    logic key_level;
    logic press_pulse;
    logic release_pulse;
    logic busy;

    int unsigned cyc = 0;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          is_press;
        int unsigned cyc;
    } exp_t;

    exp_t sb[$];

    key_debouncer #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (4),
        .KEY_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key_raw       (key_raw),
        .key_level     (key_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    exp_t mon_e;
    always @(negedge clk) begin
        if (!reset && (press_pulse || release_pulse)) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse cyc=%0d got press=%0b release=%0b required no pulse",
                         cyc, press_pulse, release_pulse);
            end else begin
                mon_e = sb.pop_front();
                if (press_pulse !== mon_e.is_press || release_pulse !== !mon_e.is_press ||
                    cyc != mon_e.cyc || key_level !== mon_e.is_press) begin
                    failures++;
                    $display("FAIL pulse got press=%0b release=%0b cyc=%0d level=%0b required press=%0b release=%0b cyc=%0d level=%0b",
                             press_pulse, release_pulse, cyc, key_level,
                             mon_e.is_press, !mon_e.is_press, mon_e.cyc, mon_e.is_press);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input bit is_press);
        sb.push_back('{is_press, cyc + LAT});
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout pending=%0d required 0 after %0d cycles", name, sb.size(), budget);
            sb.delete();
        end
        tick(3);
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        key_raw = 1'b1;
        tick(3);
        checks++;
        if ({key_level, press_pulse, release_pulse, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs got %b required 0000",
                     {key_level, press_pulse, release_pulse, busy});
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            checks++;
            if ({key_level, press_pulse, release_pulse, busy} !== 4'b0000 ||
                dut.state_q !== ST_RELEASED) begin
                failures++;
                $display("FAIL idle_released cyc=%0d got outputs=%b state=%0d required outputs=0000 state=%0d",
                         cyc, {key_level, press_pulse, release_pulse, busy}, dut.state_q, ST_RELEASED);
            end
        end
    endtask

    task automatic test_clean_press();
        int unsigned drive_cyc;
        int unsigned rise_cyc = 0;
        bit busy_seen = 1'b0;
        key_raw   = 1'b0;
        drive_cyc = cyc;
        push_exp(1'b1);
        for (int i = 0; i < 3 * LAT; i++) begin
            tick(1);
            if (busy) busy_seen = 1'b1;
            if (key_level && rise_cyc == 0) begin
                rise_cyc = cyc;
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL press_busy_clear got %b required 0", busy);
                end
            end
        end
        checks++;
        if (rise_cyc != drive_cyc + LAT) begin
            failures++;
            $display("FAIL press_latency got %0d required %0d", rise_cyc, drive_cyc + LAT);
        end
        checks++;
        if (!busy_seen) begin
            failures++;
            $display("FAIL press_busy got 0 required 1 during qualification");
        end
        drain("clean_press", 10);
    endtask

    task automatic test_clean_release();
        key_raw = 1'b1;
        push_exp(1'b0);
        drain("clean_release", 3 * LAT);
        checks++;
        if (key_level !== 1'b0) begin
            failures++;
            $display("FAIL release_level got %b required 0", key_level);
        end
    endtask

    task automatic test_bounce();
        for (int seg = 0; seg < 10; seg++) begin
            key_raw = (seg % 2 == 0) ? 1'b0 : 1'b1;
            tick(3);
        end
        checks++;
        if (key_level !== 1'b0) begin
            failures++;
            $display("FAIL bounce_level got %b required 0", key_level);
        end
        key_raw = 1'b0;
        push_exp(1'b1);
        drain("bounce_settle", 3 * LAT);
        checks++;
        if (key_level !== 1'b1) begin
            failures++;
            $display("FAIL bounce_level_after got %b required 1", key_level);
        end
    endtask

    task automatic test_glitch();
        key_raw = 1'b1;
        tick(D - 1);
        key_raw = 1'b0;
        tick(20);
        checks++;
        if (key_level !== 1'b1 || sb.size() != 0) begin
            failures++;
            $display("FAIL glitch_short got level=%b pending=%0d required level=1 pending=0",
                     key_level, sb.size());
        end
        key_raw = 1'b1;
        push_exp(1'b0);
        tick(D + 1);
        key_raw = 1'b0;
        push_exp(1'b1);
        drain("glitch_long", 4 * LAT);
        checks++;
        if (key_level !== 1'b1) begin
            failures++;
            $display("FAIL glitch_repress_level got %b required 1", key_level);
        end
    endtask

    task automatic test_reset_mid();
        key_raw = 1'b1;
        push_exp(1'b0);
        drain("pre_reset_release", 3 * LAT);
        key_raw = 1'b0;
        tick(6);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midqual_busy got %b required 1", busy);
        end
        reset = 1'b1;
        tick(1);
        checks++;
        if ({key_level, press_pulse, release_pulse, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL midqual_reset got %b required 0000",
                     {key_level, press_pulse, release_pulse, busy});
        end
        reset = 1'b0;
        push_exp(1'b1);
        drain("held_through_reset", 3 * LAT);
        checks++;
        if (key_level !== 1'b1) begin
            failures++;
            $display("FAIL held_level got %b required 1", key_level);
        end
    endtask

    initial begin
        reset   = 1'b1;
        key_raw = 1'b1;
        test_reset();
        test_clean_press();
        test_clean_release();
        test_bounce();
        test_glitch();
        test_reset_mid();
        tick(2 * LAT);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL final_queue got %0d required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
